// File: rtl/chipper_pkg.sv
// Shared definitions for the CHIPPER router network interface: flit layout,
// idle flit and destination extraction.
package chipper_pkg;

  localparam int unsigned FLIT_W    = 32;
  localparam int unsigned COORD_W   = 2;
  localparam int unsigned PAYLOAD_W = 26;
  localparam int unsigned STAT_W    = 16;

  // Field bit positions inside a flit
  localparam int unsigned DST_X_HI   = 31;
  localparam int unsigned DST_X_LO   = 30;
  localparam int unsigned DST_Y_HI   = 29;
  localparam int unsigned DST_Y_LO   = 28;
  localparam int unsigned DST_Z_HI   = 27;
  localparam int unsigned DST_Z_LO   = 26;
  localparam int unsigned PAYLOAD_HI = 25;
  localparam int unsigned PAYLOAD_LO = 0;

  localparam logic [FLIT_W-1:0] IDLE_FLIT = FLIT_W'(0);

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t                 dst_x;
    coord_t                 dst_y;
    coord_t                 dst_z;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  // Destination {x,y,z} of a flit
  function automatic logic [3*COORD_W-1:0] flit_dst(input logic [FLIT_W-1:0] flit);
    return flit[DST_X_HI:DST_Z_LO];
  endfunction

endpackage

// File: rtl/chipper_ni_fifo.sv
// DEPTH-entry synchronous FIFO with occupancy count, full and empty flags.
// Storage is not reset; only pointers and count are.
module chipper_ni_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [W-1:0]               i_wr_data,
  input  logic                       i_rd_en,
  output logic [W-1:0]               o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == CNT_W'(0));
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Entry storage, written at the write pointer
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/chipper_pe_ni.sv
// PE network interface for a 3D CHIPPER router: injection FIFO with
// request/grant handshake toward PEIN, registered capture of PEOUT.
// Optional statistics counters enabled by defining CHIPPER_NI_STATS_EN.
module chipper_pe_ni
  import chipper_pkg::*;
#(
  parameter coord_t      X_ADDR = 2'b01,
  parameter coord_t      Y_ADDR = 2'b01,
  parameter coord_t      Z_ADDR = 2'b01,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] pe_tx_flit,
  input  logic              pe_tx_valid,
  output logic              pe_tx_ready,
  output logic [FLIT_W-1:0] pein,
  output logic              inject_request,
  input  logic              inject_grant,
  input  logic [FLIT_W-1:0] peout,
  output logic [FLIT_W-1:0] pe_rx_flit,
  output logic              pe_rx_valid,
  output logic              misroute
`ifdef CHIPPER_NI_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_inj_cnt,
  output logic [STAT_W-1:0] stat_ej_cnt,
  output logic [STAT_W-1:0] stat_stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [3*COORD_W-1:0] MY_ADDR = {X_ADDR, Y_ADDR, Z_ADDR};

  logic [FLIT_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_capture;
  logic [FLIT_W-1:0] r_rx_flit;
  logic              r_rx_valid;
  logic              r_misroute;

  // Idle flits from the PE are accepted but never stored
  assign w_push    = pe_tx_valid && !w_full && (pe_tx_flit != IDLE_FLIT);
  assign w_pop     = !w_empty && inject_grant;
  assign w_capture = (peout != IDLE_FLIT);

  assign pe_tx_ready    = !w_full;
  assign inject_request = !w_empty;
  assign pein           = (w_count != CNT_W'(0)) ? w_head : IDLE_FLIT;
  assign pe_rx_flit     = r_rx_flit;
  assign pe_rx_valid    = r_rx_valid;
  assign misroute       = r_misroute;

  chipper_ni_fifo #(
    .DEPTH (DEPTH),
    .W     (FLIT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data (pe_tx_flit),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Capture ejected flits; valid and misroute are single-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_flit  <= IDLE_FLIT;
      r_rx_valid <= 1'b0;
      r_misroute <= 1'b0;
    end else begin
      r_rx_valid <= w_capture;
      r_misroute <= w_capture && (flit_dst(peout) != MY_ADDR);
      if (w_capture) r_rx_flit <= peout;
    end
  end

`ifdef CHIPPER_NI_STATS_EN
  logic [STAT_W-1:0] r_inj_cnt;
  logic [STAT_W-1:0] r_ej_cnt;
  logic [STAT_W-1:0] r_stall_cnt;
  logic              w_stall;

  assign w_stall        = !w_empty && !inject_grant;
  assign stat_inj_cnt   = r_inj_cnt;
  assign stat_ej_cnt    = r_ej_cnt;
  assign stat_stall_cnt = r_stall_cnt;

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inj_cnt   <= STAT_W'(0);
      r_ej_cnt    <= STAT_W'(0);
      r_stall_cnt <= STAT_W'(0);
    end else begin
      if (w_pop && (r_inj_cnt != '1))       r_inj_cnt   <= r_inj_cnt + STAT_W'(1);
      if (w_capture && (r_ej_cnt != '1))    r_ej_cnt    <= r_ej_cnt + STAT_W'(1);
      if (w_stall && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end
`endif

endmodule
